regfile_wr_decoder: RTL

- Parametrised, registered write-enable decoder for the dual-write-port register file.
- Converts two independent write requests (enable + select) into one-hot per-register write-enable vectors one cycle later.
- Resolves same-register collisions deterministically (port 1 wins) and counts them.
- Sits between writeback/issue logic and the register-file storage array; supports pipeline stall.

---
 rtl/regfile_wr_decoder_if.sv | 28 ++
 rtl/regfile_wr_decoder.sv | 51 +++++
 2 files changed

// File: rtl/regfile_wr_decoder_if.sv
// Request/response bundle between writeback/issue logic and the register-file write decoder.
interface regfile_wr_decoder_if #(
  parameter int SEL_W = 5,
  parameter int CNT_W = 8
);
  localparam int DEPTH = 2 ** SEL_W;

  logic             stall;
  logic             wr0_en;
  logic [SEL_W-1:0] wr0_sel;
  logic             wr1_en;
  logic [SEL_W-1:0] wr1_sel;
  logic [DEPTH-1:0] we0_out;
  logic [DEPTH-1:0] we1_out;
  logic [DEPTH-1:0] we_any_out;
  logic             conflict;
  logic [CNT_W-1:0] conflict_count;

  modport master (
    output stall, wr0_en, wr0_sel, wr1_en, wr1_sel,
    input  we0_out, we1_out, we_any_out, conflict, conflict_count
  );

  modport slave (
    input  stall, wr0_en, wr0_sel, wr1_en, wr1_sel,
    output we0_out, we1_out, we_any_out, conflict, conflict_count
  );
endinterface

// File: rtl/regfile_wr_decoder.sv
// Registered dual-port one-hot write-enable decoder; port 1 wins collisions.
// Optional macro REGFILE_ZERO_PROTECT_EN suppresses all writes to register 0.
module regfile_wr_decoder #(
  parameter int SEL_W = 5,
  parameter int CNT_W = 8
) (
  input logic             clock,
  input logic             ctrl_reset,
  regfile_wr_decoder_if.slave bus
);
  localparam int DEPTH = 2 ** SEL_W;
  localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  logic             eff0;
  logic             eff1;
  logic             hit;
  logic [DEPTH-1:0] nxt0;
  logic [DEPTH-1:0] nxt1;

  always_comb begin
    eff0 = bus.wr0_en;
    eff1 = bus.wr1_en;
`ifdef REGFILE_ZERO_PROTECT_EN
    if (bus.wr0_sel == '0) eff0 = 1'b0;
    if (bus.wr1_sel == '0) eff1 = 1'b0;
`endif
    // collision is judged on enables after zero suppression
    hit  = eff0 && eff1 && (bus.wr0_sel == bus.wr1_sel);
    nxt0 = '0;
    nxt1 = '0;
    if (eff0 && !hit) nxt0 = ONE << bus.wr0_sel;
    if (eff1)         nxt1 = ONE << bus.wr1_sel;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      bus.we0_out        <= '0;
      bus.we1_out        <= '0;
      bus.we_any_out     <= '0;
      bus.conflict       <= 1'b0;
      bus.conflict_count <= '0;
    end else if (!bus.stall) begin
      bus.we0_out    <= nxt0;
      bus.we1_out    <= nxt1;
      bus.we_any_out <= nxt0 | nxt1;
      bus.conflict   <= hit;
      if (hit && (bus.conflict_count != {CNT_W{1'b1}}))
        bus.conflict_count <= bus.conflict_count + CNT_W'(1);
    end
  end
endmodule
